// File: rtl/excp_pkg.sv
// excp_pkg: shared definitions for the commit/exception unit.
//   - EXC_* bit positions inside the 16-bit exception vector
//   - EXC_PRIO: resolution order, highest priority first
//   - state_e: commit FSM states
//   - is_mem_fault / is_fetch_fault: classify a one-hot winner for BADV capture
package excp_pkg;

  localparam logic [3:0] EXC_INT  = 4'd0;
  localparam logic [3:0] EXC_ADEF = 4'd1;
  localparam logic [3:0] EXC_TLBR = 4'd2;
  localparam logic [3:0] EXC_PIF  = 4'd3;
  localparam logic [3:0] EXC_PPI  = 4'd4;
  localparam logic [3:0] EXC_ADEM = 4'd5;
  localparam logic [3:0] EXC_ALE  = 4'd6;
  localparam logic [3:0] EXC_PIL  = 4'd7;
  localparam logic [3:0] EXC_PIS  = 4'd8;
  localparam logic [3:0] EXC_PME  = 4'd9;
  localparam logic [3:0] EXC_INE  = 4'd13;
  localparam logic [3:0] EXC_SYS  = 4'd14;
  localparam logic [3:0] EXC_BRK  = 4'd15;

  localparam int NUM_PRIO = 13;

  // Entry 0 is the highest priority source.
  localparam logic [3:0] EXC_PRIO [NUM_PRIO] = '{
    EXC_INT, EXC_ADEF, EXC_TLBR, EXC_PIF, EXC_PPI, EXC_INE, EXC_SYS,
    EXC_BRK, EXC_ALE, EXC_ADEM, EXC_PIL, EXC_PIS, EXC_PME
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Data-side faults: BADV takes the faulting data address.
  function automatic logic is_mem_fault(input logic [15:0] onehot);
    return onehot[EXC_ALE] | onehot[EXC_ADEM] | onehot[EXC_PIL] |
           onehot[EXC_PIS] | onehot[EXC_PME];
  endfunction

  // Fetch-side faults: BADV takes the instruction PC. TLB refill is
  // treated as a fetch refill here since the vector carries no side bit.
  function automatic logic is_fetch_fault(input logic [15:0] onehot);
    return onehot[EXC_ADEF] | onehot[EXC_PIF] | onehot[EXC_PPI] |
           onehot[EXC_TLBR];
  endfunction

endpackage

// File: rtl/except_commit_if.sv
// except_commit_if: MEM -> commit retire bundle.
//   master: MEM stage (drives in_valid and instruction payload, reads in_ready)
//   slave : except_commit (reads payload, drives in_ready)
interface except_commit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int CSRNUM_WIDTH = 14
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_pc;
  logic [15:0]             in_excp;
  logic [DATA_WIDTH-1:0]   in_badv;
  logic                    in_is_ertn;
  logic                    in_csr_wen;
  logic [CSRNUM_WIDTH-1:0] in_csr_waddr;
  logic [DATA_WIDTH-1:0]   in_csr_wdata;

  modport master (
    output in_valid, in_pc, in_excp, in_badv, in_is_ertn,
           in_csr_wen, in_csr_waddr, in_csr_wdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_excp, in_badv, in_is_ertn,
           in_csr_wen, in_csr_waddr, in_csr_wdata,
    output in_ready
  );
endinterface

// File: rtl/excp_prio_enc.sv
// excp_prio_enc: fixed-priority resolver for the 16-bit exception vector.
//   vec    in  16  raw exception vector (interrupt already merged)
//   onehot out 16  winning source only
//   any    out 1   some prioritised source is set
// Bits 10..12 are not exception sources and never win.
module excp_prio_enc
  import excp_pkg::*;
(
  input  logic [15:0] vec,
  output logic [15:0] onehot,
  output logic        any
);

  // Walk from lowest to highest priority so the last hit left standing wins.
  always_comb begin
    onehot = 16'd0;
    for (int i = NUM_PRIO - 1; i >= 0; i--) begin
      onehot = vec[EXC_PRIO[i]] ? (16'd1 << EXC_PRIO[i]) : onehot;
    end
    any = |onehot;
  end

endmodule

// File: rtl/except_commit.sv
// except_commit: writeback-boundary commit / exception unit.
//   clk, rst            clock, synchronous active-high reset
//   mem (slave)         retiring instruction from MEM (valid/ready handshake)
//   is_interrupt, era, trap_entry   status from the CSR file
//   etype, epc, badv_wen, badv, is_ertn, csr_wen/waddr/wdata  to the CSR file
//   flush, redirect_pc  pipeline kill and fetch redirect
//   commit_valid, commit_pc  normal retirement report
// All outputs are registered single-cycle results of the previous capture.
// After a flush the unit spends one FLUSH cycle (not ready) and then
// DRAIN_CYCLES cycles swallowing wrong-path instructions.
module except_commit
  import excp_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CSRNUM_WIDTH = 14,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  except_commit_if.slave          mem,
  input  logic                    is_interrupt,
  input  logic [DATA_WIDTH-1:0]   era,
  input  logic [DATA_WIDTH-1:0]   trap_entry,
  output logic [DATA_WIDTH-1:0]   etype,
  output logic [DATA_WIDTH-1:0]   epc,
  output logic                    badv_wen,
  output logic [DATA_WIDTH-1:0]   badv,
  output logic                    is_ertn,
  output logic                    csr_wen,
  output logic [CSRNUM_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0]   csr_wdata,
  output logic                    flush,
  output logic [DATA_WIDTH-1:0]   redirect_pc,
  output logic                    commit_valid,
  output logic [DATA_WIDTH-1:0]   commit_pc
);

  state_e      state_r;
  logic [3:0]  drain_cnt_r;
  logic [15:0] exc_vec_s;
  logic [15:0] win_s;
  logic        trap_s;
  logic        accept_s;

  // Merge the pending interrupt into the vector as the INT source.
  always_comb begin
    exc_vec_s           = mem.in_excp;
    exc_vec_s[EXC_INT]  = mem.in_excp[EXC_INT] | is_interrupt;
    accept_s            = mem.in_valid & mem.in_ready;
  end

  excp_prio_enc u_prio (
    .vec    (exc_vec_s),
    .onehot (win_s),
    .any    (trap_s)
  );

  // Commit FSM with registered outputs; pulses default to 0 every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      drain_cnt_r  <= 4'd0;
      mem.in_ready <= 1'b1;
      etype        <= '0;
      epc          <= '0;
      badv_wen     <= 1'b0;
      badv         <= '0;
      is_ertn      <= 1'b0;
      csr_wen      <= 1'b0;
      csr_waddr    <= '0;
      csr_wdata    <= '0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
    end else begin
      etype        <= '0;
      epc          <= '0;
      badv_wen     <= 1'b0;
      badv         <= '0;
      is_ertn      <= 1'b0;
      csr_wen      <= 1'b0;
      csr_waddr    <= '0;
      csr_wdata    <= '0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;

      case (state_r)
        IDLE: begin
          if (accept_s && trap_s) begin
            // Trap wins over ertn and suppresses any CSR write.
            etype       <= {{(DATA_WIDTH-16){1'b0}}, win_s};
            epc         <= mem.in_pc;
            flush       <= 1'b1;
            redirect_pc <= trap_entry;
            if (is_fetch_fault(win_s)) begin
              badv_wen <= 1'b1;
              badv     <= mem.in_pc;
            end else if (is_mem_fault(win_s)) begin
              badv_wen <= 1'b1;
              badv     <= mem.in_badv;
            end else begin
              badv_wen <= 1'b0;
            end
            state_r      <= FLUSH;
            mem.in_ready <= 1'b0;
          end else if (accept_s && mem.in_is_ertn) begin
            is_ertn      <= 1'b1;
            flush        <= 1'b1;
            redirect_pc  <= era;
            commit_valid <= 1'b1;
            commit_pc    <= mem.in_pc;
            state_r      <= FLUSH;
            mem.in_ready <= 1'b0;
          end else if (accept_s) begin
            commit_valid <= 1'b1;
            commit_pc    <= mem.in_pc;
            csr_wen      <= mem.in_csr_wen;
            csr_waddr    <= mem.in_csr_waddr;
            csr_wdata    <= mem.in_csr_wdata;
            mem.in_ready <= 1'b1;
          end else begin
            mem.in_ready <= 1'b1;
          end
        end
        FLUSH: begin
          drain_cnt_r  <= 4'(DRAIN_CYCLES - 1);
          state_r      <= DRAIN;
          mem.in_ready <= 1'b1;
        end
        DRAIN: begin
          // Accepted wrong-path instructions are dropped without any output.
          mem.in_ready <= 1'b1;
          if (drain_cnt_r == 4'd0) begin
            state_r <= IDLE;
          end else begin
            drain_cnt_r <= drain_cnt_r - 4'd1;
          end
        end
        default: begin
          state_r      <= IDLE;
          drain_cnt_r  <= 4'd0;
          mem.in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_except_commit.sv
// tb_except_commit: directed self-checking bench for except_commit.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so each sample shows the result of the capture at that edge.
module tb_except_commit;
  import excp_pkg::*;

  logic        clk;
  logic        rst;
  logic        is_interrupt;
  logic [31:0] era;
  logic [31:0] trap_entry;
  logic [31:0] etype;
  logic [31:0] epc;
  logic        badv_wen;
  logic [31:0] badv;
  logic        is_ertn;
  logic        csr_wen;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        commit_valid;
  logic [31:0] commit_pc;

  int errors = 0;
  int checks = 0;

  except_commit_if mem_if ();

  except_commit dut (
    .clk          (clk),
    .rst          (rst),
    .mem          (mem_if),
    .is_interrupt (is_interrupt),
    .era          (era),
    .trap_entry   (trap_entry),
    .etype        (etype),
    .epc          (epc),
    .badv_wen     (badv_wen),
    .badv         (badv),
    .is_ertn      (is_ertn),
    .csr_wen      (csr_wen),
    .csr_waddr    (csr_waddr),
    .csr_wdata    (csr_wdata),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    mem_if.in_valid     = 1'b0;
    mem_if.in_pc        = 32'h0;
    mem_if.in_excp      = 16'h0;
    mem_if.in_badv      = 32'h0;
    mem_if.in_is_ertn   = 1'b0;
    mem_if.in_csr_wen   = 1'b0;
    mem_if.in_csr_waddr = 14'h0;
    mem_if.in_csr_wdata = 32'h0;
    is_interrupt        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One flush cycle plus three drain cycles with nothing offered.
  task automatic wait_idle();
    clear_inputs();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    era        = 32'h1c000400;
    trap_entry = 32'h1c008000;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (mem_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", mem_if.in_ready); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b exp 0", flush); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b exp 0", commit_valid); end
    checks++; if (etype !== 32'h0) begin errors++; $display("FAIL reset_etype: got %h exp 0", etype); end
  endtask

  task automatic test_normal_csr();
    mem_if.in_valid     = 1'b1;
    mem_if.in_pc        = 32'h1c000100;
    mem_if.in_csr_wen   = 1'b1;
    mem_if.in_csr_waddr = 14'h30;
    mem_if.in_csr_wdata = 32'hdeadbeef;
    tick();
    checks++; if (csr_wen !== 1'b1) begin errors++; $display("FAIL norm_csr_wen: got %b exp 1", csr_wen); end
    checks++; if (csr_waddr !== 14'h30) begin errors++; $display("FAIL norm_waddr: got %h exp 30", csr_waddr); end
    checks++; if (csr_wdata !== 32'hdeadbeef) begin errors++; $display("FAIL norm_wdata: got %h exp deadbeef", csr_wdata); end
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL norm_commit: got %b exp 1", commit_valid); end
    checks++; if (commit_pc !== 32'h1c000100) begin errors++; $display("FAIL norm_pc: got %h exp 1c000100", commit_pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL norm_flush: got %b exp 0", flush); end
    checks++; if (mem_if.in_ready !== 1'b1) begin errors++; $display("FAIL norm_ready: got %b exp 1", mem_if.in_ready); end
    // Back-to-back: second instruction with no CSR write.
    mem_if.in_pc      = 32'h1c000104;
    mem_if.in_csr_wen = 1'b0;
    tick();
    checks++; if (commit_pc !== 32'h1c000104) begin errors++; $display("FAIL b2b_pc: got %h exp 1c000104", commit_pc); end
    checks++; if (csr_wen !== 1'b0) begin errors++; $display("FAIL b2b_csr_wen: got %b exp 0", csr_wen); end
    clear_inputs();
    tick();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL idle_commit: got %b exp 0", commit_valid); end
  endtask

  task automatic test_sys_brk_drain();
    mem_if.in_valid     = 1'b1;
    mem_if.in_pc        = 32'h1c000200;
    mem_if.in_excp      = 16'hc000;
    mem_if.in_csr_wen   = 1'b1;
    mem_if.in_csr_waddr = 14'h5;
    mem_if.in_csr_wdata = 32'h12345678;
    mem_if.in_is_ertn   = 1'b1;
    trap_entry          = 32'h1c008000;
    tick();
    checks++; if (etype !== 32'h00004000) begin errors++; $display("FAIL sys_etype: got %h exp 00004000", etype); end
    checks++; if (epc !== 32'h1c000200) begin errors++; $display("FAIL sys_epc: got %h exp 1c000200", epc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL sys_flush: got %b exp 1", flush); end
    checks++; if (redirect_pc !== 32'h1c008000) begin errors++; $display("FAIL sys_redirect: got %h exp 1c008000", redirect_pc); end
    checks++; if (csr_wen !== 1'b0) begin errors++; $display("FAIL sys_csr_sup: got %b exp 0", csr_wen); end
    checks++; if (is_ertn !== 1'b0) begin errors++; $display("FAIL sys_ertn: got %b exp 0", is_ertn); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL sys_commit: got %b exp 0", commit_valid); end
    checks++; if (badv_wen !== 1'b0) begin errors++; $display("FAIL sys_badv_wen: got %b exp 0", badv_wen); end
    checks++; if (mem_if.in_ready !== 1'b0) begin errors++; $display("FAIL sys_ready: got %b exp 0", mem_if.in_ready); end
    // Wrong-path instructions keep arriving, some with an interrupt pending.
    clear_inputs();
    mem_if.in_valid = 1'b1;
    mem_if.in_pc    = 32'h1c000300;
    tick();
    checks++; if (mem_if.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", mem_if.in_ready); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_pulse: got %b exp 0", flush); end
    is_interrupt   = 1'b1;
    mem_if.in_excp = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (commit_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL drain_%0d: commit %b flush %b exp 0 0", i, commit_valid, flush); end
      checks++; if (mem_if.in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready_%0d: got %b exp 1", i, mem_if.in_ready); end
    end
    clear_inputs();
    mem_if.in_valid = 1'b1;
    mem_if.in_pc    = 32'h1c000300;
    tick();
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL resume_commit: got %b exp 1", commit_valid); end
    checks++; if (commit_pc !== 32'h1c000300) begin errors++; $display("FAIL resume_pc: got %h exp 1c000300", commit_pc); end
    clear_inputs();
    tick();
  endtask

  task automatic test_badv();
    mem_if.in_valid = 1'b1;
    mem_if.in_pc    = 32'h1c000500;
    mem_if.in_excp  = 16'h0040;
    mem_if.in_badv  = 32'h00000003;
    tick();
    checks++; if (badv_wen !== 1'b1) begin errors++; $display("FAIL ale_badv_wen: got %b exp 1", badv_wen); end
    checks++; if (badv !== 32'h00000003) begin errors++; $display("FAIL ale_badv: got %h exp 00000003", badv); end
    checks++; if (etype !== 32'h00000040) begin errors++; $display("FAIL ale_etype: got %h exp 00000040", etype); end
    wait_idle();
    mem_if.in_valid = 1'b1;
    mem_if.in_pc    = 32'h1c000001;
    mem_if.in_excp  = 16'h0002;
    mem_if.in_badv  = 32'h0badbad0;
    tick();
    checks++; if (badv_wen !== 1'b1) begin errors++; $display("FAIL adef_badv_wen: got %b exp 1", badv_wen); end
    checks++; if (badv !== 32'h1c000001) begin errors++; $display("FAIL adef_badv: got %h exp 1c000001", badv); end
    checks++; if (etype !== 32'h00000002) begin errors++; $display("FAIL adef_etype: got %h exp 00000002", etype); end
    checks++; if (epc !== 32'h1c000001) begin errors++; $display("FAIL adef_epc: got %h exp 1c000001", epc); end
    wait_idle();
  endtask

  task automatic test_int_over_ertn();
    mem_if.in_valid   = 1'b1;
    mem_if.in_pc      = 32'h1c000580;
    mem_if.in_is_ertn = 1'b1;
    is_interrupt      = 1'b1;
    tick();
    checks++; if (etype !== 32'h00000001) begin errors++; $display("FAIL int_etype: got %h exp 00000001", etype); end
    checks++; if (is_ertn !== 1'b0) begin errors++; $display("FAIL int_ertn: got %b exp 0", is_ertn); end
    checks++; if (redirect_pc !== 32'h1c008000) begin errors++; $display("FAIL int_redirect: got %h exp 1c008000", redirect_pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL int_flush: got %b exp 1", flush); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL int_commit: got %b exp 0", commit_valid); end
    wait_idle();
  endtask

  task automatic test_ertn();
    mem_if.in_valid   = 1'b1;
    mem_if.in_pc      = 32'h1c000600;
    mem_if.in_is_ertn = 1'b1;
    era               = 32'h1c000400;
    tick();
    checks++; if (is_ertn !== 1'b1) begin errors++; $display("FAIL ertn_pulse: got %b exp 1", is_ertn); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL ertn_flush: got %b exp 1", flush); end
    checks++; if (redirect_pc !== 32'h1c000400) begin errors++; $display("FAIL ertn_redirect: got %h exp 1c000400", redirect_pc); end
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL ertn_commit: got %b exp 1", commit_valid); end
    checks++; if (etype !== 32'h0) begin errors++; $display("FAIL ertn_etype: got %h exp 0", etype); end
    checks++; if (mem_if.in_ready !== 1'b0) begin errors++; $display("FAIL ertn_ready: got %b exp 0", mem_if.in_ready); end
    wait_idle();
  endtask

  task automatic test_reset_in_drain();
    mem_if.in_valid = 1'b1;
    mem_if.in_pc    = 32'h1c000700;
    mem_if.in_excp  = 16'h8000;
    tick();
    checks++; if (etype !== 32'h00008000) begin errors++; $display("FAIL brk_etype: got %h exp 00008000", etype); end
    clear_inputs();
    tick();
    tick();
    // Second drain cycle: reset with a fresh instruction already offered.
    rst             = 1'b1;
    mem_if.in_valid = 1'b1;
    mem_if.in_pc    = 32'h1c000800;
    tick();
    rst = 1'b0;
    checks++; if (mem_if.in_ready !== 1'b1) begin errors++; $display("FAIL rstd_ready: got %b exp 1", mem_if.in_ready); end
    checks++; if (commit_valid !== 1'b0 || flush !== 1'b0 || etype !== 32'h0) begin errors++; $display("FAIL rstd_outputs: commit %b flush %b etype %h exp 0", commit_valid, flush, etype); end
    tick();
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL rstd_commit: got %b exp 1", commit_valid); end
    checks++; if (commit_pc !== 32'h1c000800) begin errors++; $display("FAIL rstd_pc: got %h exp 1c000800", commit_pc); end
    clear_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    era        = 32'h0;
    trap_entry = 32'h0;
    test_reset();
    test_normal_csr();
    test_sys_brk_drain();
    test_badv();
    test_int_over_ertn();
    test_ertn();
    test_reset_in_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/except_commit.md
Name: except_commit

Overview:
- Writeback-boundary commit/exception unit. Sits directly upstream of the CSR file.
- Accepts one retiring instruction per cycle from MEM and resolves its exception vector against the pending-interrupt flag by fixed priority.
- Drives the CSR write port, etype/epc/badv, and ertn signalling.
- Produces the pipeline flush and redirect PC, then drains wrong-path instructions before resuming normal commit.

Parameters:
- DATA_WIDTH, 32, datapath / PC width.
- CSRNUM_WIDTH, 14, CSR address width.
- DRAIN_CYCLES, 3, cycles of wrong-path kill after a flush; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  MEM offers a retiring instruction
- in_ready  out  1  unit accepts the instruction this cycle
- in_pc  in  32  instruction PC
- in_excp  in  16  exception vector; bit positions from the package
- in_badv  in  32  faulting data address
- in_is_ertn  in  1  instruction is ERTN
- in_csr_wen  in  1  instruction writes a CSR
- in_csr_waddr  in  14  CSR address
- in_csr_wdata  in  32  CSR write data
- is_interrupt  in  1  from CSR: enabled interrupt pending
- era  in  32  from CSR
- trap_entry  in  32  from CSR
- etype  out  32  one-hot winning exception, to CSR
- epc  out  32  faulting PC, to CSR
- badv_wen  out  1  BADV update strobe
- badv  out  32  BADV value
- is_ertn  out  1  ERTN commit pulse
- csr_wen  out  1  CSR write strobe
- csr_waddr  out  14  CSR write address
- csr_wdata  out  32  CSR write data
- flush  out  1  kill all younger pipeline state
- redirect_pc  out  32  fetch target, valid with flush
- commit_valid  out  1  normal instruction retired
- commit_pc  out  32  retired PC

Behaviour:
- Accept rule: capture when in_valid && in_ready.
- States:
  - IDLE: in_ready=1.
  - FLUSH: in_ready=0.
  - DRAIN: in_ready=1, accepted inputs discarded.
- Exception vector: exc_vec = in_excp, with bit INT forced to 1 if is_interrupt at capture.
- Priority, highest first: INT, ADEF, TLBR, PIF, PPI, INE, SYS, BRK, ALE, ADEM, PIL, PIS, PME. The winner only sets its etype bit; all other etype bits are 0.
- Output latency: every output is registered. An instruction captured in cycle N drives outputs in cycle N+1 only, as single-cycle pulses. Outputs are 0 when no capture occurred.
- Trap case (any exc_vec bit set):
  - etype = winning one-hot, epc = in_pc.
  - flush = 1, redirect_pc = trap_entry sampled at N.
  - badv_wen = 1 with badv = in_pc for ADEF/PIF/PPI/TLBR-fetch; badv = in_badv for ALE/ADEM/PIL/PIS/PME. Otherwise badv_wen = 0.
  - csr_wen, is_ertn and commit_valid are 0.
  - State IDLE → FLUSH.
- ERTN case (no exception, in_is_ertn):
  - is_ertn = 1, flush = 1, redirect_pc = era sampled at N.
  - commit_valid = 1.
  - State IDLE → FLUSH.
- Normal case:
  - commit_valid = 1, commit_pc = in_pc.
  - csr_wen/waddr/wdata forwarded.
  - Stay IDLE; back-to-back accepts allowed.
- FLUSH: lasts exactly 1 cycle. Load drain_cnt = DRAIN_CYCLES-1, go to DRAIN.
- DRAIN:
  - Accepted inputs produce no outputs, even if they carry exceptions or interrupts.
  - drain_cnt decrements each cycle; at drain_cnt==0, go to IDLE the next cycle.
- Simultaneous events:
  - Exception + ertn: exception wins, is_ertn=0.
  - Exception + csr_wen: write suppressed.
  - Interrupt + ertn: interrupt wins.
- Reset, including mid-FLUSH/DRAIN: state=IDLE, drain_cnt=0, all outputs 0, in_ready=1 on the cycle after rst deasserts.
- Width rules: all PC and data paths are 32 bit; no arithmetic beyond the 4-bit drain counter.

Decomposition:
- Shared package (excp_pkg):
  - EXC_* bit-index constants for the 16-bit vector: INT=0, ADEF=1, TLBR=2, PIF=3, PPI=4, ADEM=5, ALE=6, PIL=7, PIS=8, PME=9, INE=13, SYS=14, BRK=15.
  - Priority-order constant array.
  - State enum {IDLE, FLUSH, DRAIN}.
  - Helper function is_mem_fault().
- Sub-module excp_prio_enc: combinational 16-bit priority encoder producing the one-hot winner and an any-bit flag.

Test Plan:
1. Normal CSR write: pc=0x1c000100, csr_wen=1, waddr=0x30, wdata=0xdeadbeef → next cycle: csr_wen=1 with those values, commit_valid=1, commit_pc=0x1c000100, flush=0. Back-to-back accept continues.
2. SYS+BRK together: in_excp bits 14 and 15, pc=0x1c000200, trap_entry=0x1c008000 → etype=0x00004000, epc=0x1c000200, flush=1, redirect_pc=0x1c008000. in_ready=0 for 1 cycle, then 3 DRAIN cycles discard valid inputs (no commit_valid).
3. ALE: in_badv=0x00000003 → badv_wen=1, badv=0x3. ADEF at pc=0x1c000001 → badv=0x1c000001, etype bit1 set.
4. Interrupt overrides ertn: is_interrupt=1 with in_is_ertn=1 → etype=0x1, is_ertn=0, redirect_pc=trap_entry.
5. ERTN alone: era=0x1c000400 → is_ertn=1, flush=1, redirect_pc=0x1c000400, commit_valid=1.
6. rst asserted in the 2nd DRAIN cycle → next cycle all outputs 0, in_ready=1. A fresh normal instruction commits the following cycle.
